// File: rtl/des_pkg.sv
// des_pkg: shared Triple-DES block width, slave address map and result-buffer status-word layout.
package des_pkg;
    localparam int DES_BLOCK_W = 64;
    localparam logic [31:0] ADDR_RESULT = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0111;
    localparam int ST_UNDERFLOW = 0;
    localparam int ST_OVERFLOW = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_FULL = 3;
    localparam int ST_COUNT_LSB = 4;
endpackage

// File: rtl/des_result_mem.sv
// des_result_mem: DEPTH x DATA_W register array with one write port and a registered, loadable read port.
module des_result_mem #(
    parameter int DEPTH = 8,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     ld,
    input  logic                     ld_mem,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic [DATA_W-1:0]        ld_val,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    // storage array; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // read register: loads either the addressed entry or an override value, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (ld) rdata <= ld_mem ? mem[raddr] : ld_val;
    end
endmodule

// File: rtl/des_result_buffer.sv
// des_result_buffer: in-order result FIFO between the 3DES pipeline and the AHB-Lite slave.
// Status-word reads are enabled by defining DES_RESULT_BUF_STATUS_EN.
module des_result_buffer
    import des_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DATA_W = DES_BLOCK_W,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              blk_valid,
    input  logic [DATA_W-1:0] blk_data,
    input  logic              rd_en,
    input  logic              rd_status,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic data_rd, pop, push, drop, under;
    logic [CNT_W-1:0] count_nxt;
    logic [DATA_W-1:0] ld_val;
`ifdef DES_RESULT_BUF_STATUS_EN
    // status reads return a flag snapshot; data reads that underflow return zero
    always_comb begin
        ld_val = '0;
        if (rd_status) begin
            ld_val[ST_COUNT_LSB +: CNT_W] = count;
            ld_val[ST_FULL] = full;
            ld_val[ST_EMPTY] = empty;
            ld_val[ST_OVERFLOW] = overflow;
            ld_val[ST_UNDERFLOW] = underflow;
        end
    end
    assign data_rd = rd_en && !rd_status;
`else
    logic unused_rd_status;
    assign unused_rd_status = rd_status;
    assign ld_val = '0;
    assign data_rd = rd_en;
`endif
    // a pop on a full FIFO frees the slot the simultaneous push needs
    always_comb begin
        pop = data_rd && !empty;
        under = data_rd && empty;
        push = blk_valid && (!full || pop);
        drop = blk_valid && full && !pop;
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end
    // pointers, registered occupancy flags and sticky errors (a new error beats clr_err)
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            overflow <= 1'b0;
            underflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count <= count_nxt;
            full <= count_nxt == CNT_W'(DEPTH);
            empty <= count_nxt == '0;
            overflow <= drop || (overflow && !clr_err);
            underflow <= under || (underflow && !clr_err);
            rd_valid <= rd_en;
        end
    end
    des_result_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .clk(HCLK),
        .rst(HRESET),
        .we(push),
        .waddr(wr_ptr),
        .wdata(blk_data),
        .ld(rd_en),
        .ld_mem(pop),
        .raddr(rd_ptr),
        .ld_val(ld_val),
        .rdata(rd_data)
    );
endmodule

// File: tb/tb_des_result_buffer.sv
// tb_des_result_buffer: table-driven directed checks of des_result_buffer plus reset and status-read sequences.
module tb_des_result_buffer;
    logic HCLK = 1'b0, HRESET = 1'b1;
    logic blk_valid = 1'b0, rd_en = 1'b0, rd_status = 1'b0, clr_err = 1'b0;
    logic [63:0] blk_data = '0, rd_data;
    logic rd_valid, full, empty, overflow, underflow;
    logic [3:0] count;
    int checks = 0, errors = 0;

    typedef struct {
        logic bv; logic [63:0] bd; logic re, rs, ce;
        logic rv, chk; logic [63:0] rd; int cnt; logic ov, un;
    } vec_t;
    vec_t tbl[$];

    des_result_buffer #(.DEPTH(8), .DATA_W(64), .CNT_W(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .blk_valid(blk_valid), .blk_data(blk_data),
        .rd_en(rd_en), .rd_status(rd_status), .clr_err(clr_err), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [63:0] d(int i);
        return {32'h5EED_0000 | 32'(i), 32'hC0FF_EE00 ^ 32'(i * 7)};
    endfunction

    function automatic void add(logic bv, logic [63:0] bd, logic re, logic ce,
                                logic rv, logic chk, logic [63:0] rd, int cnt, logic ov, logic un);
        vec_t v;
        v.bv = bv; v.bd = bd; v.re = re; v.rs = 1'b0; v.ce = ce;
        v.rv = rv; v.chk = chk; v.rd = rd; v.cnt = cnt; v.ov = ov; v.un = un;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(logic bv, logic [63:0] bd, logic re, logic rs, logic ce);
        blk_valid = bv; blk_data = bd; rd_en = re; rd_status = rs; clr_err = ce;
        @(posedge HCLK);
        #1;
        blk_valid = 1'b0; rd_en = 1'b0; rd_status = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        // basic ordered push/pop
        add(1, 64'h8fe0d9c6b3674857, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 64'h0ec42b5c22a87f17, 0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 1, 0, 1, 1, 64'h8fe0d9c6b3674857, 1, 0, 0);
        add(0, 0, 1, 0, 1, 1, 64'h0ec42b5c22a87f17, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 64'h0ec42b5c22a87f17, 0, 0, 0);
        // fill, overflow drop, clear, push+pop while full, drain
        for (int k = 0; k < 8; k++) add(1, d(k), 0, 0, 0, 0, 0, k + 1, 0, 0);
        add(1, 64'hfa6f5f3315be4600, 0, 0, 0, 0, 0, 8, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 8, 0, 0);
        add(1, d(8), 1, 0, 1, 1, d(0), 8, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 1, 1, d(k), 8 - k, 0, 0);
        // empty reads, clear in the same cycle as a new underflow, then alone
        add(0, 0, 1, 0, 1, 1, 64'h0, 0, 0, 1);
        add(0, 0, 1, 1, 1, 1, 64'h0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // push and read on an empty FIFO: read underflows, push is kept
        add(1, d(9), 1, 0, 1, 1, 64'h0, 1, 0, 1);
        add(0, 0, 1, 0, 1, 1, d(9), 0, 0, 1);
        add(0, 0, 0, 1, 0, 1, d(9), 0, 0, 0);
        // both sticky flags set, then cleared by clr_err alone
        for (int k = 0; k < 8; k++) add(1, d(20 + k), 0, 0, 0, 0, 0, k + 1, 0, 0);
        add(1, d(99), 0, 0, 0, 0, 0, 8, 1, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 1, 0, 1, 1, d(20 + k), 7 - k, 1, 0);
        add(0, 0, 1, 0, 1, 1, 64'h0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // interleaved 10 pushes / 10 pops across the pointer wrap
        add(1, d(40), 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k < 10; k++) add(1, d(40 + k), 1, 0, 1, 1, d(39 + k), 1, 0, 0);
        add(0, 0, 1, 0, 1, 1, d(49), 0, 0, 0);

        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        chk("reset rd_data", rd_data, 64'h0);
        chk("reset rd_valid", 64'(rd_valid), 64'h0);
        chk("reset count", 64'(count), 64'h0);
        chk("reset full", 64'(full), 64'h0);
        chk("reset empty", 64'(empty), 64'h1);
        chk("reset flags", 64'({overflow, underflow}), 64'h0);

        foreach (tbl[i]) begin
            step(tbl[i].bv, tbl[i].bd, tbl[i].re, tbl[i].rs, tbl[i].ce);
            chk($sformatf("v%0d rd_valid", i), 64'(rd_valid), 64'(tbl[i].rv));
            if (tbl[i].chk) chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].rd);
            chk($sformatf("v%0d count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("v%0d full", i), 64'(full), 64'(tbl[i].cnt == 8));
            chk($sformatf("v%0d empty", i), 64'(empty), 64'(tbl[i].cnt == 0));
            chk($sformatf("v%0d overflow", i), 64'(overflow), 64'(tbl[i].ov));
            chk($sformatf("v%0d underflow", i), 64'(underflow), 64'(tbl[i].un));
        end

        // status read with three blocks queued
        for (int k = 0; k < 3; k++) step(1, d(60 + k), 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("status rd_valid", 64'(rd_valid), 64'h1);
`ifdef DES_RESULT_BUF_STATUS_EN
        chk("status word", rd_data, 64'h0000_0000_0000_0030);
        chk("status count", 64'(count), 64'h3);
`else
        chk("status-as-data rd_data", rd_data, d(60));
        chk("status-as-data count", 64'(count), 64'h2);
`endif
        chk("status underflow", 64'(underflow), 64'h0);

        // asynchronous reset between clock edges
        #2 HRESET = 1'b1;
        #1;
        chk("async count", 64'(count), 64'h0);
        chk("async empty", 64'(empty), 64'h1);
        chk("async rd_data", rd_data, 64'h0);
        #2 HRESET = 1'b0;
        step(1, d(70), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("post-reset rd_data", rd_data, d(70));
        chk("post-reset count", 64'(count), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/des_result_buffer.md
# des_result_buffer

Output buffer between the Triple-DES round pipeline and the AHB-Lite slave controller. Captures each completed 64-bit cipher/plain block the fixed-latency pipeline emits, holds it in a small FIFO, and returns blocks in order when the slave decodes a read of the result address. It also produces full, empty, count and sticky error flags for the slave's status path.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2
- DATA_W, 64, block width in bits
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count
- HCLK  in  1  system clock, rising edge
- HRESET  in  1  reset, asynchronous, active-high
- blk_valid  in  1  pipeline has a completed block this cycle (single-cycle pulse per block)
- blk_data  in  DATA_W  completed block, valid with blk_valid
- rd_en  in  1  slave read strobe for the result address, one cycle per read
- rd_status  in  1  with rd_en, selects the status word instead of data (only used under the macro)
- clr_err  in  1  clears both sticky error flags
- rd_data  out  DATA_W  read return, registered
- rd_valid  out  1  rd_data valid, exactly one cycle after rd_en
- count  out  CNT_W  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a block was dropped because the FIFO was full
- underflow  out  1  sticky: a data read was issued while the FIFO was empty

## Operation
- Storage is a DEPTH-entry register array with wr_ptr and rd_ptr, each log2(DEPTH) bits. Pointers wrap modulo DEPTH by natural rollover.
- Push: blk_valid && !full writes mem[wr_ptr], increments wr_ptr, and increments count.
- The pipeline cannot stall. blk_valid && full drops the block, sets overflow, and leaves pointers and count unchanged.
- Pop: rd_en && !rd_status && !empty loads rd_data <= mem[rd_ptr], increments rd_ptr, and decrements count.
- Data read with rd_en && !rd_status while empty: rd_data <= 0, underflow set, no pointer movement.
- Simultaneous push and pop:
  - Not full and not empty: both occur; count unchanged.
  - Full: the pop frees a slot in the same cycle, so the push is accepted and overflow is not set.
  - Empty: the read underflows (returns 0, sets underflow); the push is accepted and count becomes 1. There is no bypass.
- clr_err clears overflow and underflow. If a new error occurs in the same cycle as clr_err, the set wins.
- rd_data holds its last value when there is no read.

## Timing
- Reset values: rd_data=0, rd_valid=0, count=0, full=0, empty=1, overflow=0, underflow=0, both pointers 0. Memory contents are not reset.
- A reset asserted mid-operation discards all buffered blocks immediately, independent of HCLK.
- Push latency: count, full and empty update on the edge that samples blk_valid. A pushed block can be popped by an rd_en on the following cycle.
- Read latency: rd_data and rd_valid are valid 1 cycle after the rd_en edge, i.e. the slave's AHB data phase.
- count, full and empty are registered outputs, not combinational from the inputs.

## Configuration
- DES_RESULT_BUF_STATUS_EN
  - Defined: rd_en && rd_status returns {count zero-extended into bits [CNT_W+3:4], full, empty, overflow, underflow} in bits [3:0], remaining bits 0. A status read has no pointer side effect and never sets underflow.
  - Undefined: rd_status is ignored; every rd_en is a data read.

## Structure
- The shared package des_pkg holds:
  - DES_BLOCK_W = 64
  - result and status address constants: ADDR_RESULT = 32'h0000_0000, ADDR_STATUS = 32'h0000_0111
  - the status-word bit-position constants
- One sub-module, des_result_mem: DEPTH x DATA_W register array with one write port and one registered read port. Pointer, count and flag logic stay in des_result_buffer.

## Test plan
- Reset, push 64'h8fe0d9c6b3674857 then 64'h0ec42b5c22a87f17, read twice -> rd_data returns them in that order, one cycle after each rd_en; count 2->1->0; empty=1 at the end.
- Push 8 blocks (DEPTH=8), then a 9th block 64'hfa6f5f3315be4600 -> full=1, overflow=1, count=8; draining returns the first 8 blocks and never the dropped one.
- With full=1, blk_valid and rd_en in the same cycle -> the oldest block is returned, the new block is stored, count stays 8, overflow stays 0.
- Read while empty -> rd_data=0, rd_valid=1, underflow=1. clr_err in the same cycle as a second empty read -> underflow remains 1.
- Cause overflow and underflow, assert clr_err alone -> both flags 0. Push 10 blocks and pop 10 in an interleaved sequence -> pointers wrap and data order is preserved.
- Macro defined, 3 blocks queued, rd_en with rd_status=1 -> rd_data = 64'h0000_0000_0000_0030, count still 3; asynchronous HRESET pulse mid-stream -> count=0, empty=1 immediately.
